fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the RV32I pipeline. It serves NUM_SRC register read ports from NUM_FWD in-flight write stages and adds a registered scoreboard for multi-cycle (long-latency) operations. It produces per-source bypass selects, a load-use/long-op stall, and an issue-accept for the long-latency unit. It sits beside the decode/execute boundary and drives the operand bypass muxes and the pipeline stall/freeze network.

## Interface
- NUM_SRC, 2: number of source read ports.
- NUM_FWD, 2: number of forwarding stages; index 0 is the youngest (EX/MEM), index NUM_FWD-1 the oldest.
- SLOTS, 4: long-latency scoreboard entries.
- LAT_W, 4: width of the long-op latency counter.
- SEL_W, $clog2(NUM_FWD+1): width of one bypass select.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- src_adr  in  5*NUM_SRC  source register addresses, port i at [5i+4:5i].
- src_used  in  NUM_SRC  port i actually reads its register.
- fwd_rd_en  in  NUM_FWD  stage j writes a register.
- fwd_rd_adr  in  5*NUM_FWD  stage j destination address.
- fwd_is_load  in  NUM_FWD  stage j data not yet available (load in flight).
- lg_issue_valid  in  1  long op requests issue.
- lg_issue_rd  in  5  long op destination.
- lg_issue_lat  in  LAT_W  cycles until the result is written back.
- fwd_sel  out  SEL_W*NUM_SRC  0 = register file, j+1 = stage j.
- stall  out  1  freeze decode and fetch this cycle.
- lg_issue_ready  out  1  long op accepted this cycle.
- lg_done  out  1  a scoreboard entry retires this cycle.
- lg_done_rd  out  5  destination of the retiring entry.
- sb_busy  out  1  any scoreboard entry valid.

## Operation
- Bypass, per port i: choose the lowest j with fwd_rd_en[j], fwd_rd_adr[j]!=0 and fwd_rd_adr[j]==src_adr port i. Then fwd_sel=j+1. If there is no match, or src_used[i]=0, or the address is x0, fwd_sel=0.
- Load-use: if the selected stage j has fwd_is_load[j]=1, stall=1. fwd_sel still reports j+1.
- Scoreboard entry fields: valid, rd[4:0], cnt[LAT_W-1:0].
- An issue is accepted (lg_issue_ready=1) only when:
  - a free slot exists in the pre-edge state, and
  - no valid entry already has rd==lg_issue_rd (WAW check).
- An issue to x0 is always ready and allocates no slot.
- Allocation takes the lowest-index free slot. cnt is loaded with max(lg_issue_lat,1).
- Each cycle every valid entry decrements cnt.
- An entry with cnt==1 drives lg_done=1 and lg_done_rd=rd, then is invalidated at the edge.
- If several entries have cnt==1, the lowest index retires. The others hold at cnt==1 until it is their turn (one writeback port).
- Long-op RAW: a port with src_used=1 and a nonzero src_adr equal to any valid entry's rd forces stall=1.
- stall = load-use OR long-op RAW OR (lg_issue_valid AND NOT lg_issue_ready).

## Timing
- fwd_sel, stall, lg_issue_ready, lg_done and lg_done_rd are combinational from the inputs and registered scoreboard state. There are zero cycles of input-to-output latency.
- Scoreboard state changes only at clk rising edge.
- Reset: all slots invalid, all cnt=0.
- Post-reset outputs with all inputs low: fwd_sel=0, stall=0, lg_issue_ready=1, lg_done=0, lg_done_rd=0, sb_busy=0.
- An entry issued with lat=N asserts lg_done in the Nth cycle after the accepting edge. It no longer stalls readers from the following cycle.
- Same-cycle retire and issue: the retiring slot is not reusable that cycle, because allocation uses the pre-edge state. An issue to the retiring rd is still blocked by the WAW check.
- Reset asserted mid-operation clears every entry at that edge. No lg_done is produced for the dropped entries.
- The scoreboard is full when all SLOTS are valid. An issue in that state is not accepted and stall=1.

## Configuration
- FWD_HAZARD_STATS_EN defined adds two outputs, both cleared by reset:
  - stall_cycles, 32 bits: increments every cycle with stall=1 and saturates at 0xFFFFFFFF.
  - lg_issues, 16 bits: counts accepted non-x0 long issues and wraps.
- Without the macro, these ports, counters and logic are absent and the rest of the behaviour is identical.

## Test plan
- Defaults, stage0 rd=x5 en, stage1 rd=x5 en, src0=x5 used -> fwd_sel[0]=1 (youngest wins), stall=0. Repeat with src0=x0 -> fwd_sel[0]=0.
- stage0 load rd=x7, src1=x7 used -> stall=1, fwd_sel[1]=1. Same with src_used[1]=0 -> stall=0.
- Issue rd=x9 lat=3, then src0=x9 used on following cycles -> stall=1 for 3 cycles. lg_done=1 with lg_done_rd=9 in the 3rd cycle; stall=0 on the 4th.
- Issue 4 distinct rds with lat=15, then a 5th -> lg_issue_ready=0, stall=1. Issue of a pending rd with a free slot -> ready=0.
- Two entries reach cnt==1 together (slots 0 and 2) -> lg_done from slot 0, then slot 2 the next cycle. Reset mid-flight -> sb_busy=0 the next cycle and no lg_done.
- With FWD_HAZARD_STATS_EN: 5 stall cycles and 2 accepted issues -> stall_cycles=5, lg_issues=2. Both reads 0 after reset.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand bypass select, load-use / long-op stall and a small
//               registered scoreboard for long-latency operations.
//               Optional build macro FWD_HAZARD_STATS_EN adds the
//               stall_cycles and lg_issues event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int SLOTS   = 4,
    parameter int LAT_W   = 4,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5*NUM_SRC-1:0]     src_adr,
    input  logic [NUM_SRC-1:0]       src_used,
    input  logic [NUM_FWD-1:0]       fwd_rd_en,
    input  logic [5*NUM_FWD-1:0]     fwd_rd_adr,
    input  logic [NUM_FWD-1:0]       fwd_is_load,
    input  logic                     lg_issue_valid,
    input  logic [4:0]               lg_issue_rd,
    input  logic [LAT_W-1:0]         lg_issue_lat,
    output logic [SEL_W*NUM_SRC-1:0] fwd_sel,
    output logic                     stall,
    output logic                     lg_issue_ready,
    output logic                     lg_done,
    output logic [4:0]               lg_done_rd,
`ifdef FWD_HAZARD_STATS_EN
    output logic [31:0]              stall_cycles,
    output logic [15:0]              lg_issues,
`endif
    output logic                     sb_busy
);

    localparam logic [LAT_W-1:0] c_CNT_ONE  = LAT_W'(1);
    localparam logic [SLOTS-1:0] c_SLOT_ONE = SLOTS'(1);
    localparam logic [4:0]       c_X0       = 5'd0;

    // Scoreboard state
    logic [SLOTS-1:0] r_valid;
    logic [4:0]       r_rd  [SLOTS];
    logic [LAT_W-1:0] r_cnt [SLOTS];

    logic [SLOTS-1:0]   w_cnt_one;
    logic [SLOTS-1:0]   w_waw_hit;
    logic [SLOTS-1:0]   w_done_oh;
    logic [SLOTS-1:0]   w_free_oh;
    logic [NUM_SRC-1:0] w_load_use;
    logic [NUM_SRC-1:0] w_raw;
    logic               w_accept;
    logic [LAT_W-1:0]   w_lat_ld;

    // Per-slot status: ready-to-retire and destination clash with the issue
    for (genvar gs = 0; gs < SLOTS; gs++) begin : g_slot
        assign w_cnt_one[gs] = r_valid[gs] & (r_cnt[gs] == c_CNT_ONE);
        assign w_waw_hit[gs] = r_valid[gs] & (r_rd[gs] == lg_issue_rd);
    end

    // Lowest retiring slot wins the single writeback port; lowest free slot
    // is the allocation target. Both use the pre-edge state only.
    assign w_done_oh = w_cnt_one & (~w_cnt_one + c_SLOT_ONE);
    assign w_free_oh = ~r_valid & (r_valid + c_SLOT_ONE);

    assign lg_done        = |w_cnt_one;
    assign sb_busy        = |r_valid;
    assign lg_issue_ready = (lg_issue_rd == c_X0) | ((~&r_valid) & ~(|w_waw_hit));
    assign w_accept       = lg_issue_valid & lg_issue_ready & (lg_issue_rd != c_X0);
    assign w_lat_ld       = (lg_issue_lat == '0) ? c_CNT_ONE : lg_issue_lat;

    // Destination of the retiring entry (zero when nothing retires)
    always_comb begin
        lg_done_rd = c_X0;
        for (int s = 0; s < SLOTS; s++) begin
            if (w_done_oh[s]) begin
                lg_done_rd = lg_done_rd | r_rd[s];
            end
        end
    end

    // Per read port: bypass select, load-use flag and long-op RAW flag
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [4:0]       w_adr;
        logic [SEL_W-1:0] w_sel;
        logic             w_sel_load;
        logic [SLOTS-1:0] w_pend_hit;

        assign w_adr = src_adr[5*gi +: 5];

        // Scan oldest to youngest so the youngest matching stage is kept
        always_comb begin
            w_sel      = '0;
            w_sel_load = 1'b0;
            if (src_used[gi] && (w_adr != c_X0)) begin
                for (int j = NUM_FWD - 1; j >= 0; j--) begin
                    if (fwd_rd_en[j] && (fwd_rd_adr[5*j +: 5] == w_adr)) begin
                        w_sel      = SEL_W'(j + 1);
                        w_sel_load = fwd_is_load[j];
                    end
                end
            end
        end

        // Match this port's address against every pending long-op result
        always_comb begin
            w_pend_hit = '0;
            for (int s = 0; s < SLOTS; s++) begin
                w_pend_hit[s] = r_valid[s] & (r_rd[s] == w_adr);
            end
        end

        assign fwd_sel[gi*SEL_W +: SEL_W] = w_sel;
        assign w_load_use[gi] = w_sel_load;
        assign w_raw[gi]      = src_used[gi] & (w_adr != c_X0) & (|w_pend_hit);
    end

    assign stall = (|w_load_use) | (|w_raw) | (lg_issue_valid & ~lg_issue_ready);

    // Scoreboard update: retire one entry, count the rest down, allocate
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                r_rd[s]  <= c_X0;
                r_cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SLOTS; s++) begin
                if (w_done_oh[s]) begin
                    r_valid[s] <= 1'b0;
                    r_cnt[s]   <= '0;
                end else if (r_valid[s]) begin
                    // entries waiting on the writeback port hold at one
                    if (r_cnt[s] != c_CNT_ONE) begin
                        r_cnt[s] <= r_cnt[s] - c_CNT_ONE;
                    end
                end else if (w_accept && w_free_oh[s]) begin
                    r_valid[s] <= 1'b1;
                    r_rd[s]    <= lg_issue_rd;
                    r_cnt[s]   <= w_lat_ld;
                end
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_lg_issues;

    // Saturating stall counter and wrapping accepted-issue counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_lg_issues    <= 16'd0;
        end else begin
            if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_accept) begin
                r_lg_issues <= r_lg_issues + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign lg_issues    = r_lg_issues;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_unit
// Description : Self-checking bench for fwd_hazard_unit: bypass vector table,
//               directed scoreboard sequences and a random run against a
//               slot-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int SLOTS   = 4;
    localparam int LAT_W   = 4;
    localparam int SEL_W   = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [5*NUM_SRC-1:0]     src_adr;
    logic [NUM_SRC-1:0]       src_used;
    logic [NUM_FWD-1:0]       fwd_rd_en;
    logic [5*NUM_FWD-1:0]     fwd_rd_adr;
    logic [NUM_FWD-1:0]       fwd_is_load;
    logic                     lg_issue_valid;
    logic [4:0]               lg_issue_rd;
    logic [LAT_W-1:0]         lg_issue_lat;
    logic [SEL_W*NUM_SRC-1:0] fwd_sel;
    logic                     stall;
    logic                     lg_issue_ready;
    logic                     lg_done;
    logic [4:0]               lg_done_rd;
    logic                     sb_busy;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]              stall_cycles;
    logic [15:0]              lg_issues;
`endif

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NUM_SRC (NUM_SRC),
        .NUM_FWD (NUM_FWD),
        .SLOTS   (SLOTS),
        .LAT_W   (LAT_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_adr        (src_adr),
        .src_used       (src_used),
        .fwd_rd_en      (fwd_rd_en),
        .fwd_rd_adr     (fwd_rd_adr),
        .fwd_is_load    (fwd_is_load),
        .lg_issue_valid (lg_issue_valid),
        .lg_issue_rd    (lg_issue_rd),
        .lg_issue_lat   (lg_issue_lat),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .lg_issue_ready (lg_issue_ready),
        .lg_done        (lg_done),
        .lg_done_rd     (lg_done_rd),
`ifdef FWD_HAZARD_STATS_EN
        .stall_cycles   (stall_cycles),
        .lg_issues      (lg_issues),
`endif
        .sb_busy        (sb_busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    logic        m_valid [SLOTS];
    logic [4:0]  m_rd    [SLOTS];
    int          m_rem   [SLOTS];
    int          m_done_slot;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] m_stall_cnt;
    logic [15:0] m_issues;
`endif

    logic [3:0]  e_sel;
    logic        e_stall, e_ready, e_done, e_busy;
    logic [4:0]  e_done_rd;

    task automatic model_clear();
        for (int s = 0; s < SLOTS; s++) begin
            m_valid[s] = 1'b0;
            m_rd[s]    = 5'd0;
            m_rem[s]   = 0;
        end
`ifdef FWD_HAZARD_STATS_EN
        m_stall_cnt = 32'd0;
        m_issues    = 16'd0;
`endif
    endtask

    task automatic model_eval();
        logic [4:0] a;
        logic       lu, raw, waw, found;
        int         nvalid;
        e_sel = 4'd0;
        lu    = 1'b0;
        raw   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            a = src_adr[5*i +: 5];
            if (src_used[i] && a != 5'd0) begin
                found = 1'b0;
                for (int j = 0; j < NUM_FWD; j++) begin
                    if (!found && fwd_rd_en[j] && fwd_rd_adr[5*j +: 5] == a) begin
                        found = 1'b1;
                        e_sel[SEL_W*i +: SEL_W] = SEL_W'(j + 1);
                        if (fwd_is_load[j]) lu = 1'b1;
                    end
                end
                for (int s = 0; s < SLOTS; s++)
                    if (m_valid[s] && m_rd[s] == a) raw = 1'b1;
            end
        end
        nvalid = 0;
        waw    = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (m_valid[s]) begin
                nvalid++;
                if (m_rd[s] == lg_issue_rd) waw = 1'b1;
            end
        end
        e_ready     = (lg_issue_rd == 5'd0) || (nvalid < SLOTS && !waw);
        e_busy      = (nvalid > 0);
        e_done      = 1'b0;
        e_done_rd   = 5'd0;
        m_done_slot = -1;
        for (int s = 0; s < SLOTS; s++) begin
            if (m_done_slot < 0 && m_valid[s] && m_rem[s] == 1) begin
                m_done_slot = s;
                e_done      = 1'b1;
                e_done_rd   = m_rd[s];
            end
        end
        e_stall = lu || raw || (lg_issue_valid && !e_ready);
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_step();
        int  free_slot;
        logic acc;
        model_eval();
        if (reset) begin
            model_clear();
        end else begin
`ifdef FWD_HAZARD_STATS_EN
            if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
`endif
            acc = lg_issue_valid && e_ready && (lg_issue_rd != 5'd0);
            free_slot = -1;
            for (int s = 0; s < SLOTS; s++)
                if (free_slot < 0 && !m_valid[s]) free_slot = s;
            for (int s = 0; s < SLOTS; s++) begin
                if (m_valid[s]) begin
                    if (s == m_done_slot) m_valid[s] = 1'b0;
                    else if (m_rem[s] > 1) m_rem[s] = m_rem[s] - 1;
                end
            end
            if (acc) begin
                m_valid[free_slot] = 1'b1;
                m_rd[free_slot]    = lg_issue_rd;
                m_rem[free_slot]   = (lg_issue_lat == 0) ? 1 : int'(lg_issue_lat);
`ifdef FWD_HAZARD_STATS_EN
                m_issues = m_issues + 16'd1;
`endif
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_adr        = '0;
        src_used       = '0;
        fwd_rd_en      = '0;
        fwd_rd_adr     = '0;
        fwd_is_load    = '0;
        lg_issue_valid = 1'b0;
        lg_issue_rd    = 5'd0;
        lg_issue_lat   = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input int lat);
        lg_issue_valid = 1'b1;
        lg_issue_rd    = rd;
        lg_issue_lat   = LAT_W'(lat);
    endtask

    // ---------------- bypass vector table ----------------
    typedef struct {
        logic [9:0] adr;
        logic [1:0] used;
        logic [1:0] en;
        logic [9:0] rd_adr;
        logic [1:0] is_load;
        logic [3:0] exp_sel;
        logic       exp_stall;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{{5'd0, 5'd5},  2'b01, 2'b11, {5'd5, 5'd5},   2'b00, 4'b0001, 1'b0};
        vecs[1]  = '{{5'd0, 5'd0},  2'b01, 2'b11, {5'd5, 5'd5},   2'b00, 4'b0000, 1'b0};
        vecs[2]  = '{{5'd7, 5'd0},  2'b10, 2'b01, {5'd0, 5'd7},   2'b01, 4'b0100, 1'b1};
        vecs[3]  = '{{5'd7, 5'd0},  2'b00, 2'b01, {5'd0, 5'd7},   2'b01, 4'b0000, 1'b0};
        vecs[4]  = '{{5'd0, 5'd3},  2'b01, 2'b10, {5'd3, 5'd0},   2'b00, 4'b0010, 1'b0};
        vecs[5]  = '{{5'd4, 5'd3},  2'b11, 2'b11, {5'd3, 5'd4},   2'b10, 4'b0110, 1'b1};
        vecs[6]  = '{{5'd0, 5'd6},  2'b01, 2'b11, {5'd6, 5'd6},   2'b01, 4'b0001, 1'b1};
        vecs[7]  = '{{5'd0, 5'd8},  2'b01, 2'b10, {5'd8, 5'd8},   2'b00, 4'b0010, 1'b0};
        vecs[8]  = '{{5'd0, 5'd0},  2'b11, 2'b11, {5'd0, 5'd0},   2'b11, 4'b0000, 1'b0};
        vecs[9]  = '{{5'd0, 5'd3},  2'b01, 2'b01, {5'd0, 5'd2},   2'b01, 4'b0000, 1'b0};
        vecs[10] = '{{5'd12, 5'd12}, 2'b11, 2'b11, {5'd12, 5'd12}, 2'b10, 4'b0101, 1'b0};

        model_clear();
        clear_inputs();
        reset = 1'b1;
        advance();
        advance();
        reset = 1'b0;

        // reset state with all inputs low
        settle();
        check("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ready", 32'(lg_issue_ready), 32'd1);
        check("rst_done", 32'(lg_done), 32'd0);
        check("rst_done_rd", 32'(lg_done_rd), 32'd0);
        check("rst_busy", 32'(sb_busy), 32'd0);
`ifdef FWD_HAZARD_STATS_EN
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_lg_issues", 32'(lg_issues), 32'd0);
`endif
        advance();

        // bypass table, empty scoreboard
        for (int v = 0; v < 11; v++) begin
            clear_inputs();
            src_adr     = vecs[v].adr;
            src_used    = vecs[v].used;
            fwd_rd_en   = vecs[v].en;
            fwd_rd_adr  = vecs[v].rd_adr;
            fwd_is_load = vecs[v].is_load;
            settle();
            check($sformatf("vec%0d_sel", v), 32'(fwd_sel), 32'(vecs[v].exp_sel));
            check($sformatf("vec%0d_stall", v), 32'(stall), 32'(vecs[v].exp_stall));
            advance();
        end

        // long op x9 lat 3, reader of x9 stalls three cycles
        clear_inputs();
        issue(5'd9, 3);
        settle();
        check("b_ready", 32'(lg_issue_ready), 32'd1);
        check("b_stall0", 32'(stall), 32'd0);
        advance();
        lg_issue_valid = 1'b0;
        src_adr  = {5'd0, 5'd9};
        src_used = 2'b01;
        for (int c = 1; c <= 2; c++) begin
            settle();
            check($sformatf("b_stall%0d", c), 32'(stall), 32'd1);
            check($sformatf("b_done%0d", c), 32'(lg_done), 32'd0);
            check($sformatf("b_busy%0d", c), 32'(sb_busy), 32'd1);
            advance();
        end
        issue(5'd9, 2);
        settle();
        check("b_done3", 32'(lg_done), 32'd1);
        check("b_done_rd3", 32'(lg_done_rd), 32'd9);
        check("b_stall3", 32'(stall), 32'd1);
        check("b_waw_retiring", 32'(lg_issue_ready), 32'd0);
        advance();
        lg_issue_valid = 1'b0;
        settle();
        check("b_stall4", 32'(stall), 32'd0);
        check("b_done4", 32'(lg_done), 32'd0);
        check("b_busy4", 32'(sb_busy), 32'd0);
        advance();

        // WAW with a free slot, then fill, then full and x0 behaviour
        clear_inputs();
        for (int r = 10; r <= 12; r++) begin
            issue(5'(r), 15);
            settle();
            check($sformatf("c_ready_x%0d", r), 32'(lg_issue_ready), 32'd1);
            advance();
        end
        issue(5'd11, 15);
        settle();
        check("c_waw_ready", 32'(lg_issue_ready), 32'd0);
        check("c_waw_stall", 32'(stall), 32'd1);
        advance();
        issue(5'd13, 15);
        settle();
        check("c_fourth_ready", 32'(lg_issue_ready), 32'd1);
        advance();
        issue(5'd14, 15);
        settle();
        check("c_full_ready", 32'(lg_issue_ready), 32'd0);
        check("c_full_stall", 32'(stall), 32'd1);
        check("c_full_busy", 32'(sb_busy), 32'd1);
        advance();
        issue(5'd0, 5);
        settle();
        check("c_x0_ready", 32'(lg_issue_ready), 32'd1);
        check("c_x0_stall", 32'(stall), 32'd0);
        advance();
        clear_inputs();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        settle();
        check("c_busy_after_rst", 32'(sb_busy), 32'd0);
        advance();

        // simultaneous cnt==1 in slots 0 and 2
        issue(5'd20, 4);
        advance();
        issue(5'd21, 10);
        advance();
        issue(5'd22, 2);
        advance();
        clear_inputs();
        settle();
        check("d_done_d", 32'(lg_done), 32'd0);
        advance();
        settle();
        check("d_done_e", 32'(lg_done), 32'd1);
        check("d_done_rd_e", 32'(lg_done_rd), 32'd20);
        advance();
        settle();
        check("d_done_f", 32'(lg_done), 32'd1);
        check("d_done_rd_f", 32'(lg_done_rd), 32'd22);
        advance();
        settle();
        check("d_done_g", 32'(lg_done), 32'd0);
        check("d_busy_g", 32'(sb_busy), 32'd1);
        advance();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            settle();
            check($sformatf("d_post_rst_done%0d", c), 32'(lg_done), 32'd0);
            check($sformatf("d_post_rst_busy%0d", c), 32'(sb_busy), 32'd0);
            advance();
        end

`ifdef FWD_HAZARD_STATS_EN
        // five stall cycles and two accepted issues
        reset = 1'b1;
        advance();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            src_adr     = {5'd7, 5'd0};
            src_used    = 2'b10;
            fwd_rd_en   = 2'b01;
            fwd_rd_adr  = {5'd0, 5'd7};
            fwd_is_load = 2'b01;
            advance();
        end
        clear_inputs();
        issue(5'd1, 1);
        advance();
        issue(5'd2, 1);
        advance();
        clear_inputs();
        settle();
        check("s_stall_cycles", stall_cycles, 32'd5);
        check("s_lg_issues", 32'(lg_issues), 32'd2);
        advance();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        settle();
        check("s_stall_cycles_rst", stall_cycles, 32'd0);
        check("s_lg_issues_rst", 32'(lg_issues), 32'd0);
        advance();
`endif

        // random run against the model
        reset = 1'b1;
        clear_inputs();
        advance();
        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 63) == 0);
            src_adr        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_used       = 2'($urandom_range(0, 3));
            fwd_rd_en      = 2'($urandom_range(0, 3));
            fwd_rd_adr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_is_load    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            lg_issue_valid = ($urandom_range(0, 2) == 0);
            lg_issue_rd    = 5'($urandom_range(0, 9));
            lg_issue_lat   = LAT_W'($urandom_range(0, 6));
            settle();
            model_eval();
            check("rnd_fwd_sel", 32'(fwd_sel), 32'(e_sel));
            check("rnd_stall", 32'(stall), 32'(e_stall));
            check("rnd_ready", 32'(lg_issue_ready), 32'(e_ready));
            check("rnd_done", 32'(lg_done), 32'(e_done));
            check("rnd_done_rd", 32'(lg_done_rd), 32'(e_done_rd));
            check("rnd_busy", 32'(sb_busy), 32'(e_busy));
`ifdef FWD_HAZARD_STATS_EN
            check("rnd_stall_cycles", stall_cycles, m_stall_cnt);
            check("rnd_lg_issues", 32'(lg_issues), 32'(m_issues));
`endif
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
